// File: rtl/axi_burst_read_dma.sv
// -----------------------------------------------------------------------------
// axi_burst_read_dma
// Read-DMA channel: fetches a contiguous byte region over AXI4 as INCR bursts
// (each at most MAX_BURST_LEN beats, never crossing a 4 KB page) and forwards
// the read data beat-for-beat onto an AXI-Stream master. The stream's tready
// backpressures the AXI R channel directly. One burst is outstanding at a time.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle request, sampled only in IDLE
//   base_addr, size_bytes transfer region (sub-beat low bits dropped)
//   busy, done, error     status: busy, one-cycle done pulse, sticky error
//   m_axi_ar*             AXI4 read-address channel (master)
//   m_axi_r*              AXI4 read-data channel (master)
//   m_axis_t*             AXI-Stream output (master)
//
// state  | meaning
// -------+-------------------------------------------------------------------
// IDLE   | waiting for start
// ADDR   | zero-length check, then present one registered AR until accepted
// DATA   | pass R beats to the stream until the current burst is drained
// DONE   | one-cycle completion pulse, back to IDLE
// -----------------------------------------------------------------------------
module axi_burst_read_dma #(
   parameter int C_M_AXI_DATA_WIDTH = 128,
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int MAX_BURST_LEN      = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]   base_addr,
   input  logic [31:0]                     size_bytes,
   output logic                            busy,
   output logic                            done,
   output logic                            error,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [7:0]                      m_axi_arlen,
   output logic [2:0]                      m_axi_arsize,
   output logic [1:0]                      m_axi_arburst,
   output logic                            m_axi_arvalid,
   input  logic                            m_axi_arready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]                      m_axi_rresp,
   input  logic                            m_axi_rlast,
   input  logic                            m_axi_rvalid,
   output logic                            m_axi_rready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic                            m_axis_tlast
);

   localparam int AW         = C_M_AXI_ADDR_WIDTH;
   localparam int BEAT_BYTES = C_M_AXI_DATA_WIDTH / 8;
   localparam int OFF        = $clog2(BEAT_BYTES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [31:0]     beats_left;
   logic [AW-1:0]   cur_addr;
   logic [8:0]      burst_left;
   logic [8:0]      burst_q;
   logic [31:0]     page_beats;
   logic [31:0]     burst_calc;
   logic            ar_hs;
   logic            beat;
   logic            unused_ok;

   assign m_axi_arsize  = 3'(OFF);
   assign m_axi_arburst = 2'b01;
   assign ar_hs         = m_axi_arvalid && m_axi_arready;
   assign beat          = (state == S_DATA) && m_axi_rvalid && m_axis_tready;
   assign unused_ok     = m_axi_rresp[0];

   // Burst length: smallest of remaining beats, the cap, and beats left in the 4 KB page.
   always_comb begin
      page_beats = (32'd4096 - {20'd0, cur_addr[11:0]}) >> OFF;
      burst_calc = beats_left;
      if (burst_calc > 32'(MAX_BURST_LEN)) burst_calc = 32'(MAX_BURST_LEN);
      if (burst_calc > page_beats)         burst_calc = page_beats;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = S_ADDR;
         S_ADDR: begin
            if (beats_left == 32'd0) state_nxt = S_DONE;
            else if (ar_hs)          state_nxt = S_DATA;
         end
         S_DATA: begin
            if (beat && burst_left == 9'd1)
               state_nxt = (beats_left > 32'd1) ? S_ADDR : S_DONE;
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy          = (state == S_ADDR) || (state == S_DATA);
      done          = (state == S_DONE);
      m_axi_rready  = (state == S_DATA) && m_axis_tready;
      m_axis_tvalid = (state == S_DATA) && m_axi_rvalid;
      m_axis_tdata  = (state == S_DATA) ? m_axi_rdata : '0;
      m_axis_tlast  = (state == S_DATA) && (beats_left == 32'd1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beats_left    <= '0;
         cur_addr      <= '0;
         burst_left    <= '0;
         burst_q       <= '0;
         error         <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arlen   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  cur_addr   <= base_addr & ~(AW'(BEAT_BYTES - 1));
                  beats_left <= size_bytes >> OFF;
                  error      <= 1'b0;
               end
            end
            S_ADDR: begin
               // AR fields are captured once, then held until the handshake.
               if (!m_axi_arvalid && beats_left != 32'd0) begin
                  m_axi_arvalid <= 1'b1;
                  m_axi_araddr  <= cur_addr;
                  m_axi_arlen   <= 8'(burst_calc - 32'd1);
                  burst_q       <= 9'(burst_calc);
               end else if (ar_hs) begin
                  m_axi_arvalid <= 1'b0;
                  burst_left    <= burst_q;
                  cur_addr      <= cur_addr + (AW'(burst_q) << OFF);
               end
            end
            S_DATA: begin
               if (beat) begin
                  burst_left <= burst_left - 9'd1;
                  beats_left <= beats_left - 32'd1;
                  // Internal count decides burst end; a disagreeing rlast is only flagged.
                  if (m_axi_rresp[1] || (m_axi_rlast != (burst_left == 9'd1)))
                     error <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_burst_read_dma.sv
module tb_axi_burst_read_dma;

   localparam int DW = 128;
   localparam int AW = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [AW-1:0]   base_addr = '0;
   logic [31:0]     size_bytes = '0;
   logic            busy, done, error;
   logic [AW-1:0]   araddr;
   logic [7:0]      arlen;
   logic [2:0]      arsize;
   logic [1:0]      arburst;
   logic            arvalid;
   logic            arready = 1'b0;
   logic [DW-1:0]   rdata = '0;
   logic [1:0]      rresp = 2'b00;
   logic            rlast = 1'b0;
   logic            rvalid = 1'b0;
   logic            rready;
   logic [DW-1:0]   tdata;
   logic            tvalid;
   logic            tready = 1'b1;
   logic            tlast;

   always #5 clk = ~clk;

   axi_burst_read_dma #(
      .C_M_AXI_DATA_WIDTH(DW),
      .C_M_AXI_ADDR_WIDTH(AW),
      .MAX_BURST_LEN(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .size_bytes(size_bytes), .busy(busy), .done(done), .error(error),
      .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
      .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
      .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axis_tdata(tdata),
      .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast)
   );

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
   } ar_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   ar_t   exp_ar[$];
   beat_t exp_beat[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_beat_cyc = -10;
   int s_left = 0;
   int s_total = 0;
   int err_at = -1;
   int tr_mode = 0;   // 0: tready=1, 1: toggle each cycle, 2: random
   logic [31:0] s_addr = '0;
   logic [31:0] hs_addr = '0;
   logic [7:0]  hs_len = '0;
   bit ar_hs, r_hs;

   always @(posedge clk) cyc++;

   function automatic logic [DW-1:0] pat(logic [31:0] a);
      return {a ^ 32'hA5A5_0000, ~a, a + 32'h1234_5678, a};
   endfunction

   task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_ar(logic [31:0] a, logic [7:0] l);
      ar_t e;
      e.addr = a;
      e.len  = l;
      exp_ar.push_back(e);
   endtask

   task automatic push_beats(logic [31:0] a, int n);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b.data = pat(a + 32'(16 * i));
         b.last = (i == n - 1);
         exp_beat.push_back(b);
      end
   endtask

   // AXI slave model plus stream/AR monitor; decisions at negedge, drives at posedge+1.
   always begin
      @(negedge clk);
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      if (ar_hs) begin
         hs_addr = araddr;
         hs_len  = arlen;
         if (exp_ar.size() == 0) chk("ar_unexpected", exp_ar.size(), 1);
         else begin
            ar_t e;
            e = exp_ar.pop_front();
            chk("araddr", araddr, e.addr);
            chk("arlen", arlen, e.len);
         end
      end
      if (tvalid && tready) begin
         if (exp_beat.size() == 0) chk("beat_unexpected", exp_beat.size(), 1);
         else begin
            beat_t b;
            b = exp_beat.pop_front();
            chk("tdata", tdata, b.data);
            chk("tlast", tlast, b.last);
         end
         if (tlast) last_beat_cyc = cyc;
      end
      if (tr_mode == 1 && rvalid) chk("rready_mirror", rready, tready);
      @(posedge clk);
      #1;
      if (!rst_n) begin
         s_left  = 0;
         arready = 1'b0;
         rvalid  = 1'b0;
         rlast   = 1'b0;
         rresp   = 2'b00;
         tready  = 1'b1;
      end else begin
         if (ar_hs) begin
            s_addr = hs_addr;
            s_left = int'(hs_len) + 1;
         end
         if (r_hs) begin
            s_addr  = s_addr + 32'd16;
            s_left  = s_left - 1;
            s_total = s_total + 1;
         end
         arready = ($urandom_range(0, 3) != 0);
         rvalid  = (s_left > 0) && ((rvalid && !r_hs) || tr_mode == 1 || $urandom_range(0, 3) != 0);
         rdata   = pat(s_addr);
         rlast   = (s_left == 1);
         rresp   = (s_total == err_at) ? 2'b10 : 2'b00;
         if (tr_mode == 1)      tready = ~tready;
         else if (tr_mode == 2) tready = ($urandom_range(0, 2) != 0);
         else                   tready = 1'b1;
      end
   end

   task automatic do_start(logic [31:0] b, logic [31:0] s);
      @(posedge clk);
      #1;
      start      = 1'b1;
      base_addr  = b;
      size_bytes = s;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(string tag, bit check_lat);
      bit seen = 0;
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
      end
      chk({tag, "_done_seen"}, seen, 1);
      if (seen && check_lat) chk({tag, "_done_latency"}, cyc, last_beat_cyc + 1);
      chk({tag, "_busy_at_done"}, busy, 0);
      chk({tag, "_ar_left"}, exp_ar.size(), 0);
      chk({tag, "_beats_left"}, exp_beat.size(), 0);
   endtask

   initial begin
      int t0;
      bit hit;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_arvalid", arvalid, 0);
      chk("rst_araddr", araddr, 0);
      chk("rst_arlen", arlen, 0);
      chk("rst_rready", rready, 0);
      chk("rst_tvalid", tvalid, 0);
      chk("rst_tlast", tlast, 0);
      rst_n = 1'b1;

      // Basic: 64 beats in four 16-beat bursts
      tr_mode = 0;
      push_ar(32'h1000, 8'd15);
      push_ar(32'h1100, 8'd15);
      push_ar(32'h1200, 8'd15);
      push_ar(32'h1300, 8'd15);
      push_beats(32'h1000, 64);
      do_start(32'h0000_1000, 32'h400);
      wait_done("basic", 1);
      chk("basic_error", error, 0);
      chk("arsize", arsize, 3'd4);
      chk("arburst", arburst, 2'b01);

      // 4 KB page split, random stream backpressure
      tr_mode = 2;
      push_ar(32'h1F80, 8'd7);
      push_ar(32'h2000, 8'd7);
      push_beats(32'h1F80, 16);
      do_start(32'h0000_1F80, 32'h100);
      wait_done("split", 1);
      tr_mode = 0;

      // Short: 3 beats, also AR latency
      push_ar(32'h0100, 8'd2);
      push_beats(32'h0100, 3);
      do_start(32'h0000_0100, 32'h30);
      @(negedge clk);
      chk("short_busy_c1", busy, 1);
      chk("short_arvalid_c1", arvalid, 0);
      @(negedge clk);
      chk("short_arvalid_c2", arvalid, 1);
      wait_done("short", 1);

      // Zero length: done 2 cycles after start, no AR
      do_start(32'h0000_0200, 32'h0);
      @(negedge clk);
      chk("zero_busy_c1", busy, 1);
      chk("zero_done_c1", done, 0);
      @(negedge clk);
      chk("zero_done_c2", done, 1);
      chk("zero_busy_c2", busy, 0);
      chk("zero_arvalid", arvalid, 0);
      @(negedge clk);
      chk("zero_done_c3", done, 0);

      // Backpressure: tready toggles every cycle
      tr_mode = 1;
      push_ar(32'h0800, 8'd15);
      push_ar(32'h0900, 8'd15);
      push_beats(32'h0800, 32);
      do_start(32'h0000_0800, 32'h200);
      wait_done("bp", 1);
      tr_mode = 0;

      // SLVERR on beat 5 of 32
      err_at = s_total + 4;
      push_ar(32'h4000, 8'd15);
      push_ar(32'h4100, 8'd15);
      push_beats(32'h4000, 32);
      do_start(32'h0000_4000, 32'h200);
      wait_done("slverr", 1);
      chk("slverr_error", error, 1);
      err_at = -1;
      push_ar(32'h7000, 8'd2);
      push_beats(32'h7000, 3);
      do_start(32'h0000_7000, 32'h30);
      @(negedge clk);
      chk("error_cleared", error, 0);
      wait_done("after_err", 1);

      // Reset during beat 10 of 64
      push_ar(32'h5000, 8'd15);
      push_ar(32'h5100, 8'd15);
      push_ar(32'h5200, 8'd15);
      push_ar(32'h5300, 8'd15);
      push_beats(32'h5000, 64);
      t0 = s_total;
      do_start(32'h0000_5000, 32'h400);
      hit = 0;
      for (int n = 0; n < 4000; n++) begin
         @(posedge clk);
         #2;
         if (s_total >= t0 + 9) begin
            hit = 1;
            break;
         end
      end
      chk("midrst_reached", hit, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_arvalid", arvalid, 0);
      chk("midrst_araddr", araddr, 0);
      chk("midrst_arlen", arlen, 0);
      chk("midrst_rready", rready, 0);
      chk("midrst_tvalid", tvalid, 0);
      chk("midrst_tlast", tlast, 0);
      chk("midrst_done", done, 0);
      exp_ar.delete();
      exp_beat.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_ar(32'h3000, 8'd3);
      push_beats(32'h3000, 4);
      do_start(32'h0000_3000, 32'h40);
      wait_done("post_rst", 1);
      chk("post_rst_error", error, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
